apb_master_if: RTL
==================

APB_MASTER_IF -- requirements
Module: apb_master_if

Interface
REQ-001 Parameter APB_DATA_WIDTH, default 32, sets the data bus width; the block SHALL support only multiples of 8.
REQ-002 Parameter APB_ADDR_WIDTH, default 32, sets the address bus width.
REQ-003 Parameter TIMEOUT_CYCLE, default 16, sets the maximum ACCESS-phase cycles before abort; the block SHALL support only values of 1 or more.
REQ-004 apb_clk_in  input  1  single clock; every register SHALL sample on the rising edge.
REQ-005 apb_rstn_in  input  1  reset, asynchronous and active-low.
REQ-006 req_valid_in  input  1  user request valid.
REQ-007 req_ready_out  output  1  request accepted on the cycle where both valid and ready are high.
REQ-008 req_addr_in  input  APB_ADDR_WIDTH  request address.
REQ-009 req_write_in  input  1  1 = write, 0 = read.
REQ-010 req_wdata_in  input  APB_DATA_WIDTH  write data.
REQ-011 req_strb_in  input  APB_DATA_WIDTH/8  write byte strobes.
REQ-012 resp_valid_out  output  1  one-cycle response pulse.
REQ-013 resp_rdata_out  output  APB_DATA_WIDTH  read data.
REQ-014 resp_error_out  output  1  slave error or timeout.
REQ-015 apb_addr_out  output  APB_ADDR_WIDTH  PADDR.
REQ-016 apb_psel_out  output  1  PSEL.
REQ-017 apb_penable_out  output  1  PENABLE.
REQ-018 apb_write_out  output  1  PWRITE.
REQ-019 apb_wdata_out  output  APB_DATA_WIDTH  PWDATA.
REQ-020 apb_strb_out  output  APB_DATA_WIDTH/8  PSTRB.
REQ-021 apb_rdata_in  input  APB_DATA_WIDTH  PRDATA.
REQ-022 apb_ready_in  input  1  PREADY.
REQ-023 apb_slverr_in  input  1  PSLVERR.

Function
REQ-024 The FSM SHALL have four states: IDLE, SETUP, ACCESS and RESP.
REQ-025 In IDLE, req_ready_out SHALL be 1; in every other state it SHALL be 0.
REQ-026 On acceptance, the block SHALL register addr, write, wdata and strb, then move to SETUP; strb SHALL be registered as all-zero for reads.
REQ-027 In SETUP, psel SHALL be 1 and penable SHALL be 0 for exactly one cycle, followed by an unconditional move to ACCESS.
REQ-028 In ACCESS, psel and penable SHALL both be 1, and addr, write, wdata and strb SHALL stay stable until the state is left.
REQ-029 In ACCESS with apb_ready_in=1, the block SHALL capture rdata (0 when writing) and apb_slverr_in, then move to RESP.
REQ-030 In ACCESS with apb_ready_in=0, the wait counter SHALL increment by 1.
REQ-031 When the wait counter equals TIMEOUT_CYCLE and apb_ready_in=0, the block SHALL move to RESP with error=1 and rdata=0.
REQ-032 The wait counter SHALL be sized ceil(log2(TIMEOUT_CYCLE+1)) bits, SHALL NOT wrap, and SHALL clear on entry to SETUP.
REQ-033 In RESP, resp_valid_out SHALL be 1 for exactly one cycle, psel and penable SHALL be 0, and the next state SHALL be IDLE.
REQ-034 resp_rdata_out and resp_error_out SHALL hold their values until the next response.
REQ-035 Back-to-back throughput SHALL be one transfer per 4 cycles minimum (IDLE, SETUP, ACCESS, RESP); with ready in the first ACCESS cycle, latency from acceptance to resp_valid_out SHALL be 3 cycles.
REQ-036 If apb_ready_in=1 on the timeout cycle itself, the transfer SHALL complete normally; ready takes precedence over timeout.
REQ-037 apb_slverr_in SHALL be ignored whenever apb_ready_in=0.
REQ-038 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-039 While apb_rstn_in=0, every output and register SHALL be 0, except req_ready_out, which SHALL be 0 during reset and 1 from the first clock edge after release; the state SHALL be IDLE.
REQ-040 Reset asserted mid-transfer SHALL immediately drop psel and penable with no response emitted; after release, the block SHALL be in IDLE.

Verification
REQ-041 Write addr=0x10, data=0xA5A5_0001, strb=0xF, slave ready in the first ACCESS cycle -> one SETUP cycle, one ACCESS cycle, resp_valid 3 cycles after acceptance, error=0, rdata=0.
REQ-042 Read addr=0x20, slave holds ready low 2 cycles, then returns 0xDEAD_BEEF -> ACCESS lasts 3 cycles, resp_rdata=0xDEAD_BEEF, PSTRB=0 throughout.
REQ-043 Read with PSLVERR=1 together with PREADY -> resp_error=1; PSLVERR pulsed while PREADY=0 -> no effect.
REQ-044 Slave never ready, TIMEOUT_CYCLE=4 -> abort after 5 ACCESS cycles, resp_error=1, rdata=0, next request accepted.
REQ-045 PREADY=1 exactly on the timeout cycle -> normal completion, error=0.
REQ-046 Reset pulsed during ACCESS -> psel and penable go to 0 asynchronously, no resp_valid, req_ready=1 one edge after release.

Source files
------------

// File: rtl/apb_master_if_if.sv
// Bundles the user request/response handshake and the APB bus pins of apb_master_if.
// The master modport is the bridge's view; the slave modport is the view of whatever drives it.
interface apb_master_if_if #(
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32
);
  logic                        req_valid_in;
  logic                        req_ready_out;
  logic [APB_ADDR_WIDTH-1:0]   req_addr_in;
  logic                        req_write_in;
  logic [APB_DATA_WIDTH-1:0]   req_wdata_in;
  logic [APB_DATA_WIDTH/8-1:0] req_strb_in;
  logic                        resp_valid_out;
  logic [APB_DATA_WIDTH-1:0]   resp_rdata_out;
  logic                        resp_error_out;
  logic [APB_ADDR_WIDTH-1:0]   apb_addr_out;
  logic                        apb_psel_out;
  logic                        apb_penable_out;
  logic                        apb_write_out;
  logic [APB_DATA_WIDTH-1:0]   apb_wdata_out;
  logic [APB_DATA_WIDTH/8-1:0] apb_strb_out;
  logic [APB_DATA_WIDTH-1:0]   apb_rdata_in;
  logic                        apb_ready_in;
  logic                        apb_slverr_in;

  modport master (
    input  req_valid_in, req_addr_in, req_write_in, req_wdata_in, req_strb_in,
    input  apb_rdata_in, apb_ready_in, apb_slverr_in,
    output req_ready_out, resp_valid_out, resp_rdata_out, resp_error_out,
    output apb_addr_out, apb_psel_out, apb_penable_out, apb_write_out,
    output apb_wdata_out, apb_strb_out
  );

  modport slave (
    output req_valid_in, req_addr_in, req_write_in, req_wdata_in, req_strb_in,
    output apb_rdata_in, apb_ready_in, apb_slverr_in,
    input  req_ready_out, resp_valid_out, resp_rdata_out, resp_error_out,
    input  apb_addr_out, apb_psel_out, apb_penable_out, apb_write_out,
    input  apb_wdata_out, apb_strb_out
  );
endinterface

// File: rtl/apb_master_if.sv
// APB master bridge: accepts one user request at a time and runs it as an APB
// SETUP/ACCESS transfer with a bounded wait, returning a one-cycle response pulse.
module apb_master_if #(
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLE  = 16
) (
  input  logic             apb_clk_in,
  input  logic             apb_rstn_in,
  apb_master_if_if.master  bus
);
  localparam int STRB_W = APB_DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLE + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLE);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q;
  logic                      ready_q;
  logic                      psel_q;
  logic                      penable_q;
  logic                      resp_valid_q;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic                      write_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]         strb_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      error_q;
  logic                      accept;

  // ready_q is only high in IDLE, so it also gates the very first cycle after reset
  assign accept = bus.req_valid_in && ready_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (bus.apb_ready_in || (cnt_q == TIMEOUT_VAL)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      strb_q       <= '0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= (state_d == IDLE);
      psel_q       <= (state_d == SETUP) || (state_d == ACCESS);
      penable_q    <= (state_d == ACCESS);
      resp_valid_q <= (state_d == RESP);
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= bus.req_addr_in;
            write_q <= bus.req_write_in;
            wdata_q <= bus.req_wdata_in;
            strb_q  <= bus.req_write_in ? bus.req_strb_in : '0;
            cnt_q   <= '0;
          end
        end
        ACCESS: begin
          // ready wins over an expiring timeout; slverr only counts alongside ready
          if (bus.apb_ready_in) begin
            rdata_q <= write_q ? '0 : bus.apb_rdata_in;
            error_q <= bus.apb_slverr_in;
          end else if (cnt_q == TIMEOUT_VAL) begin
            rdata_q <= '0;
            error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready_out   = ready_q;
  assign bus.resp_valid_out  = resp_valid_q;
  assign bus.resp_rdata_out  = rdata_q;
  assign bus.resp_error_out  = error_q;
  assign bus.apb_addr_out    = addr_q;
  assign bus.apb_psel_out    = psel_q;
  assign bus.apb_penable_out = penable_q;
  assign bus.apb_write_out   = write_q;
  assign bus.apb_wdata_out   = wdata_q;
  assign bus.apb_strb_out    = strb_q;
endmodule
